// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_unit
// Description : Byte-addressed little-endian data memory with direct, indexed,
//               push and pop access modes, a bounded hardware stack pointer
//               and a valid/ready request/response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_unit #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned SP_RESET    = DEPTH,
  parameter int unsigned STACK_LIMIT = DEPTH - 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [1:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_index,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] sp
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] MODE_DIRECT  = 2'b00;
  localparam logic [1:0] MODE_INDEXED = 2'b01;
  localparam logic [1:0] MODE_PUSH    = 2'b10;
  localparam logic [1:0] MODE_POP     = 2'b11;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic [1:0]  state;

  // Request fields frozen at acceptance so the ACCESS cycle is independent
  // of whatever the requester drives afterwards.
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_mode;
  logic [31:0] lat_addr;
  logic [31:0] lat_index;
  logic [31:0] lat_wdata;

  logic [7:0]  mem [DEPTH];

  logic [2:0]       size_bytes;
  logic [31:0]      size32;
  logic [31:0]      ea;
  logic [AW-1:0]    base_idx;
  logic             is_write;
  logic             acc_err;
  logic [32:0]      end_addr;
  logic [32:0]      push_low;
  logic [32:0]      pop_high;
  logic [3:0][7:0]  rd_bytes;
  logic [31:0]      rd_ext;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // Size decode, effective address, direction and error detection.
  // Bound checks use 33-bit arithmetic so that 32-bit wrap-around and
  // stack-pointer borrow are seen as out of range rather than aliasing.
  always_comb begin
    size_bytes = 3'd0;
    case (lat_size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd0;
    endcase
    size32 = {29'd0, size_bytes};

    ea = lat_addr;
    case (lat_mode)
      MODE_DIRECT:  ea = lat_addr;
      MODE_INDEXED: ea = lat_addr + lat_index;
      MODE_PUSH:    ea = sp - size32;
      default:      ea = sp;
    endcase
    base_idx = ea[AW-1:0];

    is_write = (lat_mode == MODE_PUSH) || ((lat_mode != MODE_POP) && lat_we);

    end_addr = {1'b0, ea} + {1'b0, size32} - 33'd1;
    push_low = {1'b0, sp} - {1'b0, size32};
    pop_high = {1'b0, sp} + {1'b0, size32};

    acc_err = 1'b0;
    if (lat_size == 2'b11) begin
      acc_err = 1'b1;
    end
    if ((lat_size == SIZE_HALF) && ea[0]) begin
      acc_err = 1'b1;
    end
    if ((lat_size == SIZE_WORD) && (ea[1:0] != 2'b00)) begin
      acc_err = 1'b1;
    end
    if (end_addr >= 33'(DEPTH)) begin
      acc_err = 1'b1;
    end
    if ((lat_mode == MODE_PUSH) && (push_low[32] || (push_low < 33'(STACK_LIMIT)))) begin
      acc_err = 1'b1;
    end
    if ((lat_mode == MODE_POP) && (pop_high > 33'(SP_RESET))) begin
      acc_err = 1'b1;
    end
  end

  // Gather up to four bytes starting at EA and extend to 32 bits.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      rd_bytes[b] = mem[base_idx + AW'(b)];
    end
    rd_ext = {rd_bytes[3], rd_bytes[2], rd_bytes[1], rd_bytes[0]};
    case (lat_size)
      SIZE_BYTE: rd_ext = {{24{lat_signed & rd_bytes[0][7]}}, rd_bytes[0]};
      SIZE_HALF: rd_ext = {{16{lat_signed & rd_bytes[1][7]}}, rd_bytes[1], rd_bytes[0]};
      default:   rd_ext = {rd_bytes[3], rd_bytes[2], rd_bytes[1], rd_bytes[0]};
    endcase
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      lat_signed <= 1'b0;
      lat_mode   <= MODE_DIRECT;
      lat_addr   <= 32'd0;
      lat_index  <= 32'd0;
      lat_wdata  <= 32'd0;
    end else if ((state == ST_IDLE) && req_valid) begin
      lat_we     <= req_we;
      lat_size   <= req_size;
      lat_signed <= req_signed;
      lat_mode   <= req_mode;
      lat_addr   <= req_addr;
      lat_index  <= req_index;
      lat_wdata  <= req_wdata;
    end
  end

  // Handshake FSM, response registers and stack pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sp        <= 32'(SP_RESET);
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          state     <= ST_RESP;
          rsp_err   <= acc_err;
          rsp_rdata <= (acc_err || is_write) ? 32'd0 : rd_ext;
          if (!acc_err) begin
            if (lat_mode == MODE_PUSH) begin
              sp <= sp - size32;
            end else if (lat_mode == MODE_POP) begin
              sp <= sp + size32;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Byte-lane memory write; the array itself is never reset, and the rst
  // term keeps an aborted write from landing on an edge during reset.
  always_ff @(posedge clk) begin
    if (rst && (state == ST_ACCESS) && is_write && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (3'(b) < size_bytes) begin
          mem[base_idx + AW'(b)] <= lat_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_unit
// Description : Self-checking bench for data_mem_unit using a response
//               scoreboard and one task per feature.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_unit;

  localparam int DEPTH       = 1024;
  localparam int SP_RESET    = DEPTH;
  localparam int STACK_LIMIT = DEPTH - 256;

  localparam logic [1:0] M_DIR  = 2'b00;
  localparam logic [1:0] M_IDX  = 2'b01;
  localparam logic [1:0] M_PUSH = 2'b10;
  localparam logic [1:0] M_POP  = 2'b11;
  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_X   = 2'b11;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] index;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_sp;
  } row_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [1:0]  req_mode = 2'b00;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_index = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] sp;

  rsp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_mem_unit #(
    .DEPTH      (DEPTH),
    .SP_RESET   (SP_RESET),
    .STACK_LIMIT(STACK_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_mode  (req_mode),
    .req_addr  (req_addr),
    .req_index (req_index),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sp        (sp)
  );

  // Drive one request, record its expected response, and confirm the
  // block is busy (no response, not ready) in the cycle after acceptance.
  task automatic issue(input row_t r);
    int   n;
    rsp_t e;
    e.rdata = r.exp_rd;
    e.err   = r.exp_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid  = 1'b1;
    req_mode   = r.mode;
    req_we     = r.we;
    req_size   = r.size;
    req_signed = r.sgn;
    req_addr   = r.addr;
    req_index  = r.index;
    req_wdata  = r.wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout req_ready=%b required=1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL access_cycle rsp_valid=%b req_ready=%b required 0 and 0", rsp_valid, req_ready);
    end
  endtask

  // Wait (bounded) for the response and accept it.
  task automatic get_rsp(output rsp_t obs);
    int n;
    obs.rdata = 32'hx;
    obs.err   = 1'bx;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
    end else begin
      obs.rdata = rsp_rdata;
      obs.err   = rsp_err;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0 || sp !== 32'(SP_RESET)) begin
      failures++;
      $display("FAIL reset_state valid=%b err=%b rdata=%h sp=%h required 0 0 0 %h",
               rsp_valid, rsp_err, rsp_rdata, sp, 32'(SP_RESET));
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_direct();
    row_t rows [10];
    rsp_t obs;
    rsp_t e;
    rows = '{
      '{M_DIR, 1'b1, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0,        1'b0, 32'd1024},
      '{M_DIR, 1'b0, SZ_B, 1'b1, 32'h10, 32'h0, 32'h0,        32'hFFFFFFEF, 1'b0, 32'd1024},
      '{M_DIR, 1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'h0,        32'h0000DEAD, 1'b0, 32'd1024},
      '{M_DIR, 1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h0,        32'hFFFFDEAD, 1'b0, 32'd1024},
      '{M_DIR, 1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 32'h0,        32'h000000BE, 1'b0, 32'd1024},
      '{M_DIR, 1'b0, SZ_W, 1'b1, 32'h10, 32'h0, 32'h0,        32'hDEADBEEF, 1'b0, 32'd1024},
      '{M_DIR, 1'b1, SZ_W, 1'b0, 32'h30, 32'h0, 32'h01020304, 32'h0,        1'b0, 32'd1024},
      '{M_DIR, 1'b1, SZ_H, 1'b0, 32'h32, 32'h0, 32'hFFFFA5A5, 32'h0,        1'b0, 32'd1024},
      '{M_DIR, 1'b1, SZ_B, 1'b0, 32'h30, 32'h0, 32'h777777FF, 32'h0,        1'b0, 32'd1024},
      '{M_DIR, 1'b0, SZ_W, 1'b0, 32'h30, 32'h0, 32'h0,        32'hA5A503FF, 1'b0, 32'd1024}
    };
    foreach (rows[i]) begin
      issue(rows[i]);
      get_rsp(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e || sp !== rows[i].exp_sp) begin
        failures++;
        $display("FAIL direct[%0d] rdata=%h err=%b sp=%h required rdata=%h err=%b sp=%h",
                 i, obs.rdata, obs.err, sp, e.rdata, e.err, rows[i].exp_sp);
      end
    end
  endtask

  task automatic test_indexed();
    row_t rows [5];
    rsp_t obs;
    rsp_t e;
    rows = '{
      '{M_IDX, 1'b0, SZ_W, 1'b0, 32'h0C,       32'h04, 32'h0,        32'hDEADBEEF, 1'b0, 32'd1024},
      '{M_IDX, 1'b0, SZ_W, 1'b0, 32'hFFFFFFF0, 32'h20, 32'h0,        32'hDEADBEEF, 1'b0, 32'd1024},
      '{M_IDX, 1'b1, SZ_W, 1'b0, 32'h40,       32'h08, 32'hCAFEF00D, 32'h0,        1'b0, 32'd1024},
      '{M_DIR, 1'b0, SZ_W, 1'b0, 32'h48,       32'h00, 32'h0,        32'hCAFEF00D, 1'b0, 32'd1024},
      '{M_IDX, 1'b0, SZ_W, 1'b0, 32'h10,       32'h01, 32'h0,        32'h0,        1'b1, 32'd1024}
    };
    foreach (rows[i]) begin
      issue(rows[i]);
      get_rsp(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e || sp !== rows[i].exp_sp) begin
        failures++;
        $display("FAIL indexed[%0d] rdata=%h err=%b sp=%h required rdata=%h err=%b sp=%h",
                 i, obs.rdata, obs.err, sp, e.rdata, e.err, rows[i].exp_sp);
      end
    end
  endtask

  task automatic test_errors();
    row_t rows [10];
    rsp_t obs;
    rsp_t e;
    rows = '{
      '{M_DIR, 1'b0, SZ_W, 1'b1, 32'h11,       32'h0, 32'h0,        32'h0,        1'b1, 32'd1024},
      '{M_DIR, 1'b0, SZ_H, 1'b0, 32'h11,       32'h0, 32'h0,        32'h0,        1'b1, 32'd1024},
      '{M_DIR, 1'b0, SZ_X, 1'b0, 32'h10,       32'h0, 32'h0,        32'h0,        1'b1, 32'd1024},
      '{M_DIR, 1'b1, SZ_H, 1'b0, 32'h3FE,      32'h0, 32'h00001234, 32'h0,        1'b0, 32'd1024},
      '{M_DIR, 1'b1, SZ_W, 1'b0, 32'h3FE,      32'h0, 32'hAAAAAAAA, 32'h0,        1'b1, 32'd1024},
      '{M_DIR, 1'b0, SZ_W, 1'b0, 32'h400,      32'h0, 32'h0,        32'h0,        1'b1, 32'd1024},
      '{M_DIR, 1'b0, SZ_B, 1'b0, 32'h3FF,      32'h0, 32'h0,        32'h00000012, 1'b0, 32'd1024},
      '{M_DIR, 1'b0, SZ_B, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0,        32'h0,        1'b1, 32'd1024},
      '{M_DIR, 1'b1, SZ_B, 1'b0, 32'h400,      32'h0, 32'h55,       32'h0,        1'b1, 32'd1024},
      '{M_DIR, 1'b0, SZ_H, 1'b0, 32'h3FE,      32'h0, 32'h0,        32'h00001234, 1'b0, 32'd1024}
    };
    foreach (rows[i]) begin
      issue(rows[i]);
      get_rsp(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e || sp !== rows[i].exp_sp) begin
        failures++;
        $display("FAIL errors[%0d] rdata=%h err=%b sp=%h required rdata=%h err=%b sp=%h",
                 i, obs.rdata, obs.err, sp, e.rdata, e.err, rows[i].exp_sp);
      end
    end
  endtask

  task automatic test_stack();
    row_t rows [11];
    rsp_t obs;
    rsp_t e;
    rows = '{
      '{M_POP,  1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0,        32'h0,        1'b1, 32'd1024},
      '{M_PUSH, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h12345678, 32'h0,        1'b0, 32'd1020},
      '{M_PUSH, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0, 32'hFFFFFFAB, 32'h0,        1'b0, 32'd1019},
      '{M_POP,  1'b1, SZ_B, 1'b0, 32'h0, 32'h0, 32'h0,        32'h000000AB, 1'b0, 32'd1020},
      '{M_POP,  1'b1, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0,        32'h12345678, 1'b0, 32'd1024},
      '{M_POP,  1'b0, SZ_B, 1'b0, 32'h0, 32'h0, 32'h0,        32'h0,        1'b1, 32'd1024},
      '{M_PUSH, 1'b0, SZ_H, 1'b0, 32'h0, 32'h0, 32'h00008001, 32'h0,        1'b0, 32'd1022},
      '{M_POP,  1'b0, SZ_H, 1'b1, 32'h0, 32'h0, 32'h0,        32'hFFFF8001, 1'b0, 32'd1024},
      '{M_PUSH, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0, 32'h000000C3, 32'h0,        1'b0, 32'd1023},
      '{M_POP,  1'b0, SZ_H, 1'b0, 32'h0, 32'h0, 32'h0,        32'h0,        1'b1, 32'd1023},
      '{M_POP,  1'b0, SZ_B, 1'b1, 32'h0, 32'h0, 32'h0,        32'hFFFFFFC3, 1'b0, 32'd1024}
    };
    foreach (rows[i]) begin
      issue(rows[i]);
      get_rsp(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e || sp !== rows[i].exp_sp) begin
        failures++;
        $display("FAIL stack[%0d] rdata=%h err=%b sp=%h required rdata=%h err=%b sp=%h",
                 i, obs.rdata, obs.err, sp, e.rdata, e.err, rows[i].exp_sp);
      end
    end
  endtask

  task automatic test_overflow();
    row_t r;
    rsp_t obs;
    rsp_t e;
    int   n_ok;
    n_ok = (SP_RESET - STACK_LIMIT) / 4;
    for (int i = 0; i < n_ok + 3; i++) begin
      r = '0;
      if (i < n_ok) begin
        r.mode = M_PUSH; r.size = SZ_W; r.wdata = 32'h1000 + 32'(i);
        r.exp_sp = 32'(SP_RESET - 4 * (i + 1));
      end else if (i == n_ok) begin
        r.mode = M_PUSH; r.size = SZ_W; r.wdata = 32'hBAD0BAD0;
        r.exp_err = 1'b1; r.exp_sp = 32'(STACK_LIMIT);
      end else if (i == n_ok + 1) begin
        r.mode = M_PUSH; r.size = SZ_B; r.wdata = 32'h5A;
        r.exp_err = 1'b1; r.exp_sp = 32'(STACK_LIMIT);
      end else begin
        r.mode = M_POP; r.size = SZ_W;
        r.exp_rd = 32'h1000 + 32'(n_ok - 1); r.exp_sp = 32'(STACK_LIMIT + 4);
      end
      issue(r);
      get_rsp(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e || sp !== r.exp_sp) begin
        failures++;
        $display("FAIL overflow[%0d] rdata=%h err=%b sp=%h required rdata=%h err=%b sp=%h",
                 i, obs.rdata, obs.err, sp, e.rdata, e.err, r.exp_sp);
      end
    end
  endtask

  task automatic test_backpressure();
    row_t r;
    rsp_t obs;
    rsp_t e;
    int   n;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_rsp_ready rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end
    rsp_ready = 1'b0;
    r = '0;
    r.mode = M_DIR; r.size = SZ_W; r.addr = 32'h10; r.exp_rd = 32'hDEADBEEF;
    issue(r);
    e = sb.pop_front();
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d] valid=%b rdata=%h err=%b req_ready=%b required 1 %h %b 0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
      end
      if (c == 1) begin
        req_valid = 1'b1; req_mode = M_DIR; req_we = 1'b1; req_size = SZ_W;
        req_addr = 32'h10; req_wdata = 32'h0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL release rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end
    issue(r);
    get_rsp(obs);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL ignored_req rdata=%h err=%b required rdata=%h err=%b", obs.rdata, obs.err, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_abort();
    row_t r;
    rsp_t obs;
    rsp_t e;
    int   n;
    r = '0;
    r.mode = M_DIR; r.we = 1'b1; r.size = SZ_W; r.addr = 32'h20; r.wdata = 32'h11223344;
    issue(r);
    get_rsp(obs);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL abort_setup rdata=%h err=%b required rdata=%h err=%b", obs.rdata, obs.err, e.rdata, e.err);
    end
    // Accept a write, then pull reset during its ACCESS cycle.
    @(negedge clk);
    req_valid = 1'b1; req_mode = M_DIR; req_we = 1'b1; req_size = SZ_W;
    req_addr = 32'h20; req_wdata = 32'h55667788;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || sp !== 32'(SP_RESET)) begin
      failures++;
      $display("FAIL abort_access rsp_valid=%b sp=%h required 0 %h", rsp_valid, sp, 32'(SP_RESET));
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    r.we = 1'b0; r.wdata = 32'h0; r.exp_rd = 32'h11223344;
    issue(r);
    get_rsp(obs);
    e = sb.pop_front();
    checks++;
    if (obs !== e || sp !== 32'(SP_RESET)) begin
      failures++;
      $display("FAIL abort_readback rdata=%h err=%b sp=%h required rdata=%h err=%b sp=%h",
               obs.rdata, obs.err, sp, e.rdata, e.err, 32'(SP_RESET));
    end
    // Reset while a response is pending drops it immediately.
    issue(r);
    void'(sb.pop_front());
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL abort_resp valid=%b rdata=%h err=%b required 0 0 0", rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_recover req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_indexed();
    test_errors();
    test_stack();
    test_overflow();
    test_backpressure();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
